// File: rtl/kes_channel_requester.sv
// kes_channel_requester: channel-side requester for the shared KES arbiter.
// Buffers syndrome chunks in a small FIFO and requests the KES once a whole
// codeword group is buffered. It then hands out one chunk per grant pulse and
// flags the last chunk of the group so the arbiter can release the KES.
// Optional feature: define KES_REQ_TIMEOUT_EN to add a request-starvation
// watchdog with the sticky output oReqTimeout.
module kes_channel_requester #(
    parameter int         SYN_WIDTH        = 48,
    parameter int         DEPTH            = 8,
    parameter int         CHUNKS_PER_GROUP = 2,
    parameter logic [1:0] CHANNEL_ID       = 2'd0
) (
    input  logic                 iClock,
    input  logic                 iReset_n,
    input  logic                 iSynValid,
    input  logic [SYN_WIDTH-1:0] iSynData,
    output logic                 oSynReady,
    output logic                 oKESRequest,
    input  logic                 iKESGrant,
    output logic                 oLastChunk,
    output logic [SYN_WIDTH-1:0] oSynOut,
    output logic                 oSynOutValid,
    output logic [1:0]           oChannelNumber,
    output logic                 oGrantError
`ifdef KES_REQ_TIMEOUT_EN
    ,
    output logic                 oReqTimeout
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IG_W  = (CHUNKS_PER_GROUP > 1) ? $clog2(CHUNKS_PER_GROUP) : 1;
    localparam int GRP_W = $clog2(DEPTH / CHUNKS_PER_GROUP + 1);

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [IG_W-1:0]  LAST_IDX  = IG_W'(CHUNKS_PER_GROUP - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_LAST
    } state_e;

    state_e               state_q, state_d;
    logic [SYN_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [IG_W-1:0]      in_cnt_q, in_cnt_d;
    logic [IG_W-1:0]      out_cnt_q, out_cnt_d;
    logic [GRP_W-1:0]     grp_cnt_q, grp_cnt_d;
    logic [SYN_WIDTH-1:0] syn_out_q, syn_out_d;
    logic                 syn_out_valid_q, syn_out_valid_d;
    logic                 last_chunk_q, last_chunk_d;
    logic                 grant_error_q, grant_error_d;

    logic push, pop, pop_last, grp_inc, grp_dec;

    // Handshake qualification, FSM next state and all datapath next values.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no latch
        // can be inferred when a path leaves it unassigned.
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        in_cnt_d        = in_cnt_q;
        out_cnt_d       = out_cnt_q;
        grp_cnt_d       = grp_cnt_q;
        syn_out_d       = syn_out_q;
        syn_out_valid_d = 1'b0;
        last_chunk_d    = last_chunk_q;
        grant_error_d   = grant_error_q;
        pop             = 1'b0;

        push     = iSynValid && (count_q != FULL_CNT);
        pop_last = (out_cnt_q == LAST_IDX);

        unique case (state_q)
            ST_IDLE: begin
                if (iKESGrant && (grp_cnt_q != '0)) begin
                    pop     = 1'b1;
                    state_d = pop_last ? ST_LAST : ST_XFER;
                end
            end
            ST_XFER: begin
                if (iKESGrant && (count_q != '0)) begin
                    pop     = 1'b1;
                    state_d = pop_last ? ST_LAST : ST_XFER;
                end
            end
            ST_LAST: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A grant that cannot be served is a protocol violation; keep it sticky.
        if (iKESGrant && !pop) begin
            grant_error_d = 1'b1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            in_cnt_d = (in_cnt_q == LAST_IDX) ? '0 : in_cnt_q + IG_W'(1);
        end

        if (pop) begin
            rd_ptr_d        = rd_ptr_q + PTR_W'(1);
            out_cnt_d       = pop_last ? '0 : out_cnt_q + IG_W'(1);
            syn_out_d       = mem_q[rd_ptr_q];
            syn_out_valid_d = 1'b1;
            last_chunk_d    = pop_last;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        grp_inc = push && (in_cnt_q == LAST_IDX);
        grp_dec = pop && pop_last;
        unique case ({grp_inc, grp_dec})
            2'b10:   grp_cnt_d = grp_cnt_q + GRP_W'(1);
            2'b01:   grp_cnt_d = grp_cnt_q - GRP_W'(1);
            default: grp_cnt_d = grp_cnt_q;
        endcase
    end

    // Control and output registers, all cleared by the async reset.
    always_ff @(posedge iClock or negedge iReset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!iReset_n) begin
            state_q         <= ST_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            in_cnt_q        <= '0;
            out_cnt_q       <= '0;
            grp_cnt_q       <= '0;
            syn_out_q       <= '0;
            syn_out_valid_q <= 1'b0;
            last_chunk_q    <= 1'b0;
            grant_error_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            in_cnt_q        <= in_cnt_d;
            out_cnt_q       <= out_cnt_d;
            grp_cnt_q       <= grp_cnt_d;
            syn_out_q       <= syn_out_d;
            syn_out_valid_q <= syn_out_valid_d;
            last_chunk_q    <= last_chunk_d;
            grant_error_q   <= grant_error_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge iClock) begin
        // NOTE: the storage array has no reset; the pointers and occupancy
        // count define which entries are meaningful, so a reset would only
        // cost area and routing.
        if (push) begin
            mem_q[wr_ptr_q] <= iSynData;
        end
    end

    assign oSynReady      = (count_q != FULL_CNT);
    assign oKESRequest    = (state_q == ST_IDLE) && (grp_cnt_q != '0);
    assign oLastChunk     = last_chunk_q;
    assign oSynOut        = syn_out_q;
    assign oSynOutValid   = syn_out_valid_q;
    assign oChannelNumber = CHANNEL_ID;
    assign oGrantError    = grant_error_q;

`ifdef KES_REQ_TIMEOUT_EN
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        timeout_q, timeout_d;

    // Watchdog: counts while waiting for a grant, restarts on every grant.
    always_comb begin
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout_q;
        if (iKESGrant) begin
            to_cnt_d = '0;
        end else if ((oKESRequest || (state_q == ST_XFER)) && (to_cnt_q != 16'hFFFF)) begin
            to_cnt_d = to_cnt_q + 16'd1;
        end
        if (to_cnt_d == 16'hFFFF) begin
            timeout_d = 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign oReqTimeout = timeout_q;
`endif

endmodule

// File: tb/tb_kes_channel_requester.sv
// Directed self-checking bench for kes_channel_requester (default parameters:
// 48-bit chunks, 8-deep FIFO, 2 chunks per group, channel 0).
// Inputs change 1 ns after a rising edge; outputs are compared at that point.
module tb_kes_channel_requester;

    localparam int SYN_WIDTH = 48;

    logic                 iClock = 1'b0;
    logic                 iReset_n;
    logic                 iSynValid;
    logic [SYN_WIDTH-1:0] iSynData;
    logic                 oSynReady;
    logic                 oKESRequest;
    logic                 iKESGrant;
    logic                 oLastChunk;
    logic [SYN_WIDTH-1:0] oSynOut;
    logic                 oSynOutValid;
    logic [1:0]           oChannelNumber;
    logic                 oGrantError;

    int errors = 0;
    int checks = 0;

    kes_channel_requester #(
        .SYN_WIDTH        (SYN_WIDTH),
        .DEPTH            (8),
        .CHUNKS_PER_GROUP (2),
        .CHANNEL_ID       (2'd0)
    ) dut (
        .iClock         (iClock),
        .iReset_n       (iReset_n),
        .iSynValid      (iSynValid),
        .iSynData       (iSynData),
        .oSynReady      (oSynReady),
        .oKESRequest    (oKESRequest),
        .iKESGrant      (iKESGrant),
        .oLastChunk     (oLastChunk),
        .oSynOut        (oSynOut),
        .oSynOutValid   (oSynOutValid),
        .oChannelNumber (oChannelNumber),
        .oGrantError    (oGrantError)
    );

    always #5 iClock = ~iClock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic push(input logic [SYN_WIDTH-1:0] d);
        iSynValid = 1'b1;
        iSynData  = d;
        tick();
        iSynValid = 1'b0;
    endtask

    task automatic grant();
        iKESGrant = 1'b1;
        tick();
        iKESGrant = 1'b0;
    endtask

    task automatic apply_reset();
        iReset_n = 1'b0;
        #2;
        iReset_n = 1'b1;
        tick();
    endtask

    // Two back-to-back grants deliver one group, then LAST returns to IDLE.
    task automatic pop_group(input logic [SYN_WIDTH-1:0] e0, input logic [SYN_WIDTH-1:0] e1);
        grant();
        checks++; if (oSynOut !== e0) begin errors++; $display("FAIL grp_data0: got %h want %h", oSynOut, e0); end
        checks++; if (oSynOutValid !== 1'b1) begin errors++; $display("FAIL grp_valid0: got %b want 1", oSynOutValid); end
        checks++; if (oLastChunk !== 1'b0) begin errors++; $display("FAIL grp_last0: got %b want 0", oLastChunk); end
        checks++; if (oKESRequest !== 1'b0) begin errors++; $display("FAIL grp_req_xfer: got %b want 0", oKESRequest); end
        grant();
        checks++; if (oSynOut !== e1) begin errors++; $display("FAIL grp_data1: got %h want %h", oSynOut, e1); end
        checks++; if (oLastChunk !== 1'b1) begin errors++; $display("FAIL grp_last1: got %b want 1", oLastChunk); end
        checks++; if (oKESRequest !== 1'b0) begin errors++; $display("FAIL grp_req_last: got %b want 0", oKESRequest); end
        tick();
        checks++; if (oSynOutValid !== 1'b0) begin errors++; $display("FAIL grp_valid_pulse: got %b want 0", oSynOutValid); end
    endtask

    task automatic test_reset();
        iReset_n  = 1'b0;
        iSynValid = 1'b0;
        iSynData  = '0;
        iKESGrant = 1'b0;
        #2;
        checks++; if (oSynReady !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", oSynReady); end
        checks++; if (oKESRequest !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", oKESRequest); end
        checks++; if (oSynOutValid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", oSynOutValid); end
        checks++; if (oLastChunk !== 1'b0) begin errors++; $display("FAIL rst_last: got %b want 0", oLastChunk); end
        checks++; if (oSynOut !== 48'h0) begin errors++; $display("FAIL rst_data: got %h want 0", oSynOut); end
        checks++; if (oChannelNumber !== 2'd0) begin errors++; $display("FAIL rst_chan: got %0d want 0", oChannelNumber); end
        checks++; if (oGrantError !== 1'b0) begin errors++; $display("FAIL rst_gerr: got %b want 0", oGrantError); end
        @(posedge iClock);
        #1;
        iReset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_group();
        push(48'hAAAA_0000_0001);
        checks++; if (oKESRequest !== 1'b0) begin errors++; $display("FAIL basic_req_half: got %b want 0", oKESRequest); end
        push(48'hBBBB_0000_0002);
        checks++; if (oKESRequest !== 1'b1) begin errors++; $display("FAIL basic_req_rise: got %b want 1", oKESRequest); end
        grant();
        checks++; if (oSynOut !== 48'hAAAA_0000_0001) begin errors++; $display("FAIL basic_data_a: got %h want aaaa00000001", oSynOut); end
        checks++; if (oSynOutValid !== 1'b1) begin errors++; $display("FAIL basic_valid_a: got %b want 1", oSynOutValid); end
        checks++; if (oLastChunk !== 1'b0) begin errors++; $display("FAIL basic_last_a: got %b want 0", oLastChunk); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (oKESRequest !== 1'b0) begin errors++; $display("FAIL basic_req_xfer: got %b want 0", oKESRequest); end
            tick();
            checks++; if (oSynOutValid !== 1'b0) begin errors++; $display("FAIL basic_valid_gap: got %b want 0", oSynOutValid); end
        end
        grant();
        checks++; if (oSynOut !== 48'hBBBB_0000_0002) begin errors++; $display("FAIL basic_data_b: got %h want bbbb00000002", oSynOut); end
        checks++; if (oLastChunk !== 1'b1) begin errors++; $display("FAIL basic_last_b: got %b want 1", oLastChunk); end
        checks++; if (oKESRequest !== 1'b0) begin errors++; $display("FAIL basic_req_last: got %b want 0", oKESRequest); end
        tick();
        checks++; if (oKESRequest !== 1'b0) begin errors++; $display("FAIL basic_req_idle: got %b want 0", oKESRequest); end
        checks++; if (oLastChunk !== 1'b1) begin errors++; $display("FAIL basic_last_hold: got %b want 1", oLastChunk); end
    endtask

    task automatic test_partial_group();
        push(48'hCCCC_0000_0003);
        for (int i = 0; i < 20; i++) begin
            checks++; if (oKESRequest !== 1'b0) begin errors++; $display("FAIL partial_req_low: cycle %0d got %b want 0", i, oKESRequest); end
            tick();
        end
        push(48'hDDDD_0000_0004);
        checks++; if (oKESRequest !== 1'b1) begin errors++; $display("FAIL partial_req_rise: got %b want 1", oKESRequest); end
        pop_group(48'hCCCC_0000_0003, 48'hDDDD_0000_0004);
    endtask

    task automatic test_full_and_back_to_back();
        logic [SYN_WIDTH-1:0] base;
        base = 48'h1000_0000_0000;
        for (int i = 0; i < 8; i++) begin
            checks++; if (oSynReady !== 1'b1) begin errors++; $display("FAIL full_ready_fill: push %0d got %b want 1", i, oSynReady); end
            push(base + 48'(i));
        end
        checks++; if (oSynReady !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %b want 0", oSynReady); end
        push(48'hDEAD_DEAD_DEAD);
        checks++; if (oSynReady !== 1'b0) begin errors++; $display("FAIL full_ready_after_9th: got %b want 0", oSynReady); end
        checks++; if (oKESRequest !== 1'b1) begin errors++; $display("FAIL full_req: got %b want 1", oKESRequest); end
        pop_group(base, base + 48'd1);
        checks++; if (oSynReady !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %b want 1", oSynReady); end
        checks++; if (oKESRequest !== 1'b1) begin errors++; $display("FAIL full_req_again: got %b want 1", oKESRequest); end
        push(48'hE000_0000_0000);
        // FIFO holds 7; push and pop share the next edge.
        iSynValid = 1'b1;
        iSynData  = 48'hE000_0000_0001;
        grant();
        iSynValid = 1'b0;
        checks++; if (oSynOut !== base + 48'd2) begin errors++; $display("FAIL b2b_data: got %h want %h", oSynOut, base + 48'd2); end
        checks++; if (oSynReady !== 1'b1) begin errors++; $display("FAIL b2b_ready_7: got %b want 1", oSynReady); end
        push(48'hE000_0000_0002);
        checks++; if (oSynReady !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %b want 0", oSynReady); end
        grant();
        checks++; if (oSynOut !== base + 48'd3) begin errors++; $display("FAIL b2b_data_last: got %h want %h", oSynOut, base + 48'd3); end
        checks++; if (oLastChunk !== 1'b1) begin errors++; $display("FAIL b2b_last: got %b want 1", oLastChunk); end
        tick();
        pop_group(base + 48'd4, base + 48'd5);
        pop_group(base + 48'd6, base + 48'd7);
        pop_group(48'hE000_0000_0000, 48'hE000_0000_0001);
        checks++; if (oKESRequest !== 1'b0) begin errors++; $display("FAIL b2b_req_partial: got %b want 0", oKESRequest); end
    endtask

    task automatic test_grant_error();
        apply_reset();
        grant();
        checks++; if (oGrantError !== 1'b1) begin errors++; $display("FAIL gerr_set: got %b want 1", oGrantError); end
        checks++; if (oSynOutValid !== 1'b0) begin errors++; $display("FAIL gerr_valid: got %b want 0", oSynOutValid); end
        push(48'h5555_0000_0001);
        push(48'h5555_0000_0002);
        pop_group(48'h5555_0000_0001, 48'h5555_0000_0002);
        checks++; if (oGrantError !== 1'b1) begin errors++; $display("FAIL gerr_sticky: got %b want 1", oGrantError); end
    endtask

    task automatic test_reset_mid_xfer();
        apply_reset();
        checks++; if (oGrantError !== 1'b0) begin errors++; $display("FAIL mid_gerr_clr: got %b want 0", oGrantError); end
        push(48'h7777_0000_0001);
        push(48'h7777_0000_0002);
        push(48'h7777_0000_0003);
        push(48'h7777_0000_0004);
        pop_group(48'h7777_0000_0001, 48'h7777_0000_0002);
        checks++; if (oKESRequest !== 1'b1) begin errors++; $display("FAIL mid_req: got %b want 1", oKESRequest); end
        grant();
        checks++; if (oSynOutValid !== 1'b1) begin errors++; $display("FAIL mid_valid_pre: got %b want 1", oSynOutValid); end
        #2;
        iReset_n = 1'b0;
        #1;
        checks++; if (oSynOutValid !== 1'b0) begin errors++; $display("FAIL mid_valid_async: got %b want 0", oSynOutValid); end
        checks++; if (oKESRequest !== 1'b0) begin errors++; $display("FAIL mid_req_async: got %b want 0", oKESRequest); end
        checks++; if (oLastChunk !== 1'b0) begin errors++; $display("FAIL mid_last_async: got %b want 0", oLastChunk); end
        checks++; if (oSynReady !== 1'b1) begin errors++; $display("FAIL mid_ready_async: got %b want 1", oSynReady); end
        iReset_n = 1'b1;
        tick();
        checks++; if (oKESRequest !== 1'b0) begin errors++; $display("FAIL mid_req_after: got %b want 0", oKESRequest); end
        grant();
        checks++; if (oGrantError !== 1'b1) begin errors++; $display("FAIL mid_fifo_empty: got %b want 1", oGrantError); end
        checks++; if (oSynOutValid !== 1'b0) begin errors++; $display("FAIL mid_valid_empty: got %b want 0", oSynOutValid); end
    endtask

    initial begin
        test_reset();
        test_basic_group();
        test_partial_group();
        test_full_and_back_to_back();
        test_grant_error();
        test_reset_mid_xfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kes_channel_requester.md
Name: kes_channel_requester

Overview:
- Channel-side counterpart of the shared key-equation-solver (KES) channel arbiter; one instance per NAND channel.
- Buffers syndrome chunks from the local syndrome calculator and raises a KES request once a complete codeword group is buffered.
- Delivers one chunk per grant pulse and drives the last-chunk flag that the arbiter samples to release the KES.

Parameters:
SYN_WIDTH, 48, bits per syndrome chunk
DEPTH, 8, FIFO depth in chunks (power of two, >= 2*CHUNKS_PER_GROUP)
CHUNKS_PER_GROUP, 2, chunks per codeword group delivered under one arbitration win
CHANNEL_ID, 0, 2-bit channel tag driven on oChannelNumber

Ports:
iClock  in  1  clock
iReset_n  in  1  asynchronous active-low reset
iSynValid  in  1  input chunk valid
iSynData  in  SYN_WIDTH  input chunk
oSynReady  out  1  FIFO can accept a chunk (not full)
oKESRequest  out  1  request to arbiter (one bit of its request vector)
iKESGrant  in  1  one-cycle grant pulse (this channel's bit of the arbiter's avail vector)
oLastChunk  out  1  delivered chunk was last of group (this channel's bit of the arbiter's last-chunk vector)
oSynOut  out  SYN_WIDTH  chunk to KES input mux
oSynOutValid  out  1  oSynOut valid, one-cycle pulse
oChannelNumber  out  2  constant CHANNEL_ID
oGrantError  out  1  sticky: grant received with no chunk to give

Behaviour:
- Reset: all outputs 0 except oSynReady=1 and oChannelNumber=CHANNEL_ID; FIFO empty; counters 0; state IDLE.
- Input push when iSynValid && oSynReady; FIFO occupancy count is 0..DEPTH; a push while full is ignored (oSynReady=0 guarantees it never occurs legally).
- rGroupCnt counts complete buffered groups: it increments when a push completes a group (the in-group push counter wraps CHUNKS_PER_GROUP-1 -> 0) and decrements on the last-chunk pop. A simultaneous increment and decrement leaves it unchanged.
- State machine:
  - IDLE: oKESRequest = (rGroupCnt != 0), combinational from registers. On iKESGrant with rGroupCnt != 0, pop the head chunk and go to XFER, or to LAST if CHUNKS_PER_GROUP == 1.
  - XFER: oKESRequest=0. Wait for the next iKESGrant, then pop. Go to LAST when the popped chunk is number CHUNKS_PER_GROUP-1 of the group (out-chunk counter); otherwise stay in XFER.
  - LAST: one cycle, oKESRequest=0, then IDLE. Covers the arbiter's Dummy -> Idle transition, so the request re-evaluates from IDLE.
- Pop timing: grant at cycle G -> oSynOut/oSynOutValid registered and valid in G+1. oLastChunk is registered at the same edge: 1 in G+1 if the popped chunk is the last of the group, else 0. oLastChunk holds until the next pop, so the arbiter's sample in G+1 is valid.
- Request is raised only for a fully buffered group, so every in-group grant finds data; the arbiter never re-checks the request mid-group.
- Simultaneous push and pop in one cycle: occupancy unchanged, and both pointers advance.
- Grant with FIFO empty, or grant in LAST: no pop, oSynOutValid=0, oGrantError set (cleared only by reset).
- Reset mid-group: everything returns to reset values immediately (async). The arbiter is reset by the same network.

Optional Feature:
KES_REQ_TIMEOUT_EN
- Defined: a 16-bit counter runs while oKESRequest=1 or the state is XFER, and clears on each grant. When it reaches 16'hFFFF it sets sticky output oReqTimeout (extra 1-bit port, reset 0) and saturates.
- Undefined: no counter and no port.

Test Plan:
- Push 2 chunks A,B (CHUNKS_PER_GROUP=2) -> oKESRequest=1 the cycle after B accepted. Grant at G -> oSynOut=A, oLastChunk=0 at G+1. Grant at G+3 -> oSynOut=B, oLastChunk=1 at G+4. oKESRequest=0 throughout XFER/LAST.
- Push 1 chunk only -> oKESRequest stays 0 for 20 cycles; push 2nd -> request rises.
- Push 8 chunks with no grants -> oSynReady=0 after 8th; 9th iSynValid ignored. One group popped -> oSynReady=1, and oKESRequest=1 again in IDLE after LAST.
- Push during the grant cycle, FIFO at 7 -> occupancy stays 7 and data order is preserved over 4 grants.
- Grant pulse with empty FIFO -> oGrantError=1, oSynOutValid=0; error remains after later legal traffic until iReset_n low.
- Assert iReset_n=0 in XFER -> oKESRequest, oLastChunk, oSynOutValid=0 without waiting for a clock edge; FIFO empty after release.
